mem_dual_clr: RTL and testbench
===============================

# mem_dual_clr

Parametrised dual-port synchronous RAM: port A read/write with byte enables, port B read-only. Adds a configurable read-during-write policy, an optional output register stage, per-port read-valid flags, and a hardware zero-fill sequencer that runs after reset or on request. It is the on-chip storage primitive for the signing datapath wherever two consumers share one buffer, or where a buffer must be wiped between signatures without a software loop.

## Interface
- WIDTH, 64: word width in bits; must be a multiple of BYTE
- DEPTH, 1024: number of words, any value ≥ 2
- BYTE, 8: bits per byte-enable lane
- RDW_NEW, 0: read-during-write policy for the same address; 0 returns old data, 1 returns new merged data
- OUT_REG, 0: 0 gives read latency 1; 1 gives read latency 2
- INIT_CLEAR, 1: 1 starts a zero-fill automatically when reset is released
- clock  in  1  single clock; all logic on its rising edge
- rst_n  in  1  synchronous active-low reset
- clear  in  1  one-cycle request to zero-fill the whole array
- busy  out  1  high while the zero-fill runs; user accesses are ignored while high
- a_addr  in  CLOG2(DEPTH)  port A address, using the codebase CLOG2 macro
- a_data  in  WIDTH  port A write data
- a_be  in  WIDTH/BYTE  port A byte enables; lane i covers bits [i*BYTE +: BYTE]
- a_wr_en  in  1  port A write strobe
- a_rd_en  in  1  port A read strobe
- a_q  out  WIDTH  port A read data
- a_valid  out  1  one-cycle pulse when a_q carries a new read result
- b_addr  in  CLOG2(DEPTH)  port B address
- b_rd_en  in  1  port B read strobe
- b_q  out  WIDTH  port B read data
- b_valid  out  1  one-cycle pulse when b_q carries a new read result

## Operation
- Reset (rst_n low at an edge):
  - a_q, b_q, a_valid, b_valid are set to 0.
  - The clear counter is set to 0.
  - The FSM is set to CLEAR if INIT_CLEAR=1, otherwise IDLE. busy therefore reads INIT_CLEAR during reset.
  - Array contents are not written while rst_n is low.
- FSM states:
  - IDLE: the user ports are active. clear=1 moves to CLEAR with the counter at 0.
  - CLEAR: each cycle writes all-zero to word cnt, then cnt increments. At cnt = DEPTH-1, that word is written and the FSM returns to IDLE. busy = (state == CLEAR).
- Behaviour during CLEAR:
  - a_wr_en, a_rd_en, b_rd_en and clear are ignored. No memory write occurs and no valid pulse is issued.
  - a_q and b_q hold their values.
  - A clear request during CLEAR does not restart the counter.
- Port A write: each lane i with a_be[i]=1 takes the matching a_data lane. All other lanes keep their stored value. a_wr_en with a_be = 0 is a no-op write.
- Reads:
  - A read of address x returns mem[x] as sampled at the rd_en edge, subject to the RDW rule below.
  - a_valid and b_valid pulse for exactly one cycle per accepted read.
  - Reads with no rd_en leave q unchanged.
- RDW rule: this applies when a read (either port) of address x coincides with a port A write to x.
  - RDW_NEW=0: the read returns the pre-write word.
  - RDW_NEW=1: the read returns the byte-merged post-write word.
- a_wr_en and a_rd_en in the same cycle is legal; port A's read obeys the RDW rule.
- Both ports reading the same address in the same cycle is legal; both return the same word.
- Out-of-range addresses (≥ DEPTH, when DEPTH is not a power of 2): writes are dropped, reads return 0 with valid still pulsed.

## Timing
- Read latency:
  - OUT_REG=0: q and valid update at edge T+1 for a request sampled at edge T.
  - OUT_REG=1: q and valid update at edge T+2. The second stage is reset to 0 and is also ignored-while-busy consistent.
- Write: visible to a read issued at the next edge (T+1).
- Fully pipelined: one read per port per cycle, no stalls.
- Zero-fill:
  - Takes exactly DEPTH cycles.
  - busy falls at the edge after word DEPTH-1 is written.
  - A user access in the first cycle with busy=0 is accepted.
- clear sampled at T moves to CLEAR, so busy=1 from T+1.
- A read issued in the cycle before clear is sampled completes normally, including the OUT_REG=1 second stage.
- Reset during CLEAR aborts the fill.
  - INIT_CLEAR=1: the fill restarts from word 0 after release.
  - INIT_CLEAR=0: the block returns to IDLE, and the array is left partially cleared.

## Test plan
- Power-on with INIT_CLEAR=1, DEPTH=16:
  - busy stays high 16 cycles after rst_n rises.
  - Reads of all 16 words then return 0 with b_valid pulses.
- Byte merge, WIDTH=32:
  - Write 0xAABBCCDD to addr 3 with a_be=4'hF, then 0x11223344 with a_be=4'b0101.
  - Reading addr 3 returns 0xAA22CC44.
- RDW collision at addr 5 (holding 0x1): port A writes 0x2 while port B reads addr 5.
  - b_q=0x1 with RDW_NEW=0; b_q=0x2 with RDW_NEW=1.
- OUT_REG=1 back-to-back reads of addrs 0,1,2 on port B:
  - b_valid is high for 3 consecutive cycles starting 2 cycles after the first request, with data in order.
- clear after writes:
  - Pulse clear; a_wr_en issued during busy is dropped.
  - After busy falls, all reads return 0.
- Reset asserted at cnt=7 of a 16-word fill (INIT_CLEAR=1):
  - busy holds high; the fill restarts from word 0 and takes 16 more cycles after release.

Source files
------------

// File: rtl/mem_dual_clr.sv
// mem_dual_clr: dual-port synchronous RAM. Port A reads and writes with byte
// enables, port B only reads. Supports a selectable read-during-write policy,
// an optional output register stage, per-port read-valid pulses and a
// hardware zero-fill sequencer that runs after reset or on request.

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module mem_dual_clr #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 1024,
    parameter int BYTE       = 8,
    parameter int RDW_NEW    = 0,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      clear,
    output logic                      busy,
    input  logic [`CLOG2(DEPTH)-1:0]  a_addr,
    input  logic [WIDTH-1:0]          a_data,
    input  logic [WIDTH/BYTE-1:0]     a_be,
    input  logic                      a_wr_en,
    input  logic                      a_rd_en,
    output logic [WIDTH-1:0]          a_q,
    output logic                      a_valid,
    input  logic [`CLOG2(DEPTH)-1:0]  b_addr,
    input  logic                      b_rd_en,
    output logic [WIDTH-1:0]          b_q,
    output logic                      b_valid,
    output logic                      state_dbg
);

    localparam int AW  = `CLOG2(DEPTH);
    localparam int NBE = WIDTH / BYTE;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Request/response contract: a strobe (a_wr_en, a_rd_en, b_rd_en, clear)
    // is accepted on any rising edge where the block is in IDLE and rst_n is
    // high; there is no back-pressure. Each accepted read produces exactly one
    // single-cycle valid pulse with its data, in request order, a fixed
    // latency later. Strobes seen while busy are dropped without response.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   cnt_q;
    logic [AW-1:0]   cnt_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             idle;
    logic             a_in_range;
    logic             b_in_range;
    logic             b_hit;
    logic [WIDTH-1:0] a_old;
    logic [WIDTH-1:0] b_old;
    logic [WIDTH-1:0] a_merged;
    logic [WIDTH-1:0] a_rd_word;
    logic [WIDTH-1:0] b_rd_word;

    logic [WIDTH-1:0] a_q1;
    logic [WIDTH-1:0] b_q1;
    logic             a_v1;
    logic             b_v1;

    assign idle      = (state_q == S_IDLE);
    assign busy      = (state_q == S_CLEAR);
    assign state_dbg = state_q;

    // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
    assign a_in_range = ({1'b0, a_addr} <= {1'b0, LAST});
    assign b_in_range = ({1'b0, b_addr} <= {1'b0, LAST});
    assign b_hit      = a_wr_en && a_in_range && (a_addr == b_addr);

    // FSM state and fill-counter register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: IDLE waits for clear, CLEAR walks every word once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Current words at both addresses and the byte-merged port A write word.
    always_comb begin
        a_old    = a_in_range ? mem[a_addr] : '0;
        b_old    = b_in_range ? mem[b_addr] : '0;
        a_merged = a_old;
        for (int i = 0; i < NBE; i++) begin
            if (a_be[i]) begin
                a_merged[i*BYTE +: BYTE] = a_data[i*BYTE +: BYTE];
            end
        end
    end

    // Read data selection, applying the read-during-write policy.
    always_comb begin
        a_rd_word = a_old;
        b_rd_word = b_old;
        if (RDW_NEW != 0) begin
            if (a_wr_en && a_in_range) begin
                a_rd_word = a_merged;
            end
            if (b_hit) begin
                b_rd_word = a_merged;
            end
        end
    end

    // Array write: zero-fill has the array while busy, otherwise port A.
    always_ff @(posedge clock) begin
        if (rst_n) begin
            if (state_q == S_CLEAR) begin
                mem[cnt_q] <= '0;
            end else if (a_wr_en && a_in_range) begin
                mem[a_addr] <= a_merged;
            end
        end
    end

    // First read stage: capture data and raise valid for accepted reads.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            a_q1 <= '0;
            b_q1 <= '0;
            a_v1 <= 1'b0;
            b_v1 <= 1'b0;
        end else begin
            a_v1 <= idle && a_rd_en;
            b_v1 <= idle && b_rd_en;
            if (idle && a_rd_en) begin
                a_q1 <= a_rd_word;
            end
            if (idle && b_rd_en) begin
                b_q1 <= b_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] a_q2;
            logic [WIDTH-1:0] b_q2;
            logic             a_v2;
            logic             b_v2;

            // Second stage follows the first unconditionally so a read accepted
            // just before a clear still completes; it only loads on valid.
            always_ff @(posedge clock) begin
                if (!rst_n) begin
                    a_q2 <= '0;
                    b_q2 <= '0;
                    a_v2 <= 1'b0;
                    b_v2 <= 1'b0;
                end else begin
                    a_v2 <= a_v1;
                    b_v2 <= b_v1;
                    if (a_v1) begin
                        a_q2 <= a_q1;
                    end
                    if (b_v1) begin
                        b_q2 <= b_q1;
                    end
                end
            end

            assign a_q     = a_q2;
            assign b_q     = b_q2;
            assign a_valid = a_v2;
            assign b_valid = b_v2;
        end else begin : g_no_out_reg
            assign a_q     = a_q1;
            assign b_q     = b_q1;
            assign a_valid = a_v1;
            assign b_valid = b_v1;
        end
    endgenerate

endmodule

// File: tb/tb_mem_dual_clr.sv
// tb_mem_dual_clr: drives two mem_dual_clr instances with the same stimulus.
// dut0: DEPTH=16, old-data RDW, latency 1. dut1: DEPTH=12 (non power of two),
// new-data RDW, latency 2. Both are 32 bits wide and zero-fill on reset.

module tb_mem_dual_clr;

    localparam int W      = 32;
    localparam int DEPTH0 = 16;
    localparam int DEPTH1 = 12;

    // Clock and reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    logic         rst_n;
    logic         clear;
    logic [3:0]   a_addr;
    logic [W-1:0] a_data;
    logic [3:0]   a_be;
    logic         a_wr_en;
    logic         a_rd_en;
    logic [3:0]   b_addr;
    logic         b_rd_en;

    logic         busy0, a_v0, b_v0, st0;
    logic [W-1:0] a_q0, b_q0;
    logic         busy1, a_v1, b_v1, st1;
    logic [W-1:0] a_q1, b_q1;

    mem_dual_clr #(
        .WIDTH(W), .DEPTH(DEPTH0), .BYTE(8), .RDW_NEW(0), .OUT_REG(0), .INIT_CLEAR(1)
    ) dut0 (
        .clock(clock), .rst_n(rst_n), .clear(clear), .busy(busy0),
        .a_addr(a_addr), .a_data(a_data), .a_be(a_be), .a_wr_en(a_wr_en),
        .a_rd_en(a_rd_en), .a_q(a_q0), .a_valid(a_v0),
        .b_addr(b_addr), .b_rd_en(b_rd_en), .b_q(b_q0), .b_valid(b_v0),
        .state_dbg(st0)
    );

    mem_dual_clr #(
        .WIDTH(W), .DEPTH(DEPTH1), .BYTE(8), .RDW_NEW(1), .OUT_REG(1), .INIT_CLEAR(1)
    ) dut1 (
        .clock(clock), .rst_n(rst_n), .clear(clear), .busy(busy1),
        .a_addr(a_addr), .a_data(a_data), .a_be(a_be), .a_wr_en(a_wr_en),
        .a_rd_en(a_rd_en), .a_q(a_q1), .a_valid(a_v1),
        .b_addr(b_addr), .b_rd_en(b_rd_en), .b_q(b_q1), .b_valid(b_v1),
        .state_dbg(st1)
    );

    // Scoreboard state: each entry is {due cycle, expected data}
    int errors = 0;
    int checks = 0;
    logic [63:0]  exp_a0_q[$];
    logic [63:0]  exp_b0_q[$];
    logic [63:0]  exp_a1_q[$];
    logic [63:0]  exp_b1_q[$];
    logic [W-1:0] m0 [DEPTH0];
    logic [W-1:0] m1 [DEPTH1];
    int busy_cnt0 = 0;
    int busy_cnt1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [W-1:0] d,
                                           input logic [3:0] be);
        logic [W-1:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    // Output monitor: pop and compare on every valid pulse
    logic [63:0] e;
    always @(negedge clock) begin
        if (busy0 === 1'b1) busy_cnt0++;
        if (busy1 === 1'b1) busy_cnt1++;
        if (a_v0 === 1'b1) begin
            if (exp_a0_q.size() == 0) chk("a0_unexpected_valid", 1, 0);
            else begin
                e = exp_a0_q.pop_front();
                chk("a0_data", a_q0, {32'd0, e[31:0]});
                chk("a0_cycle", cyc, {32'd0, e[63:32]});
            end
        end
        if (b_v0 === 1'b1) begin
            if (exp_b0_q.size() == 0) chk("b0_unexpected_valid", 1, 0);
            else begin
                e = exp_b0_q.pop_front();
                chk("b0_data", b_q0, {32'd0, e[31:0]});
                chk("b0_cycle", cyc, {32'd0, e[63:32]});
            end
        end
        if (a_v1 === 1'b1) begin
            if (exp_a1_q.size() == 0) chk("a1_unexpected_valid", 1, 0);
            else begin
                e = exp_a1_q.pop_front();
                chk("a1_data", a_q1, {32'd0, e[31:0]});
                chk("a1_cycle", cyc, {32'd0, e[63:32]});
            end
        end
        if (b_v1 === 1'b1) begin
            if (exp_b1_q.size() == 0) chk("b1_unexpected_valid", 1, 0);
            else begin
                e = exp_b1_q.pop_front();
                chk("b1_data", b_q1, {32'd0, e[31:0]});
                chk("b1_cycle", cyc, {32'd0, e[63:32]});
            end
        end
    end

    // Driver: one cycle of stimulus; live=1 means both DUTs are idle and accept it
    task automatic op(input logic wr, input logic [3:0] wa, input logic [W-1:0] wd,
                      input logic [3:0] be, input logic ard, input logic brd,
                      input logic [3:0] ba, input logic live);
        logic [W-1:0] mg0, mg1, ra1, rb1;
        int due0, due1;
        a_addr = wa; a_data = wd; a_be = be; a_wr_en = wr; a_rd_en = ard;
        b_addr = ba; b_rd_en = brd;
        if (live) begin
            due0 = cyc + 1;
            due1 = cyc + 2;
            mg0  = merge(m0[wa], wd, be);
            mg1  = (int'(wa) < DEPTH1) ? merge(m1[wa], wd, be) : '0;
            ra1  = (int'(wa) < DEPTH1) ? (wr ? mg1 : m1[wa]) : '0;
            rb1  = (int'(ba) < DEPTH1) ? ((wr && wa == ba) ? mg1 : m1[ba]) : '0;
            if (ard) begin
                exp_a0_q.push_back({32'(due0), m0[wa]});
                exp_a1_q.push_back({32'(due1), ra1});
            end
            if (brd) begin
                exp_b0_q.push_back({32'(due0), m0[ba]});
                exp_b1_q.push_back({32'(due1), rb1});
            end
            if (wr) begin
                m0[wa] = mg0;
                if (int'(wa) < DEPTH1) m1[wa] = mg1;
            end
        end
        @(posedge clock); #1;
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_idle(input int exp0, input int exp1);
        for (int i = 0; i < 200 && (busy0 !== 1'b0 || busy1 !== 1'b0); i++) @(negedge clock);
        #1;
        chk("fill_done", {busy0, busy1}, 0);
        chk("busy_cycles0", busy_cnt0, exp0);
        chk("busy_cycles1", busy_cnt1, exp1);
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH0; i++) m0[i] = '0;
        for (int i = 0; i < DEPTH1; i++) m1[i] = '0;
    endtask

    // Directed sequence
    initial begin
        rst_n = 1'b0; clear = 1'b0;
        a_addr = '0; a_data = '0; a_be = '0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        b_addr = '0; b_rd_en = 1'b0;
        model_zero();
        idle(3);

        // Reset state: fill pending, outputs cleared
        chk("rst_busy0", busy0, 1);
        chk("rst_busy1", busy1, 1);
        chk("rst_state0", st0, 1);
        chk("rst_a_q0", a_q0, 0);
        chk("rst_b_q1", b_q1, 0);
        chk("rst_valids", {a_v0, b_v0, a_v1, b_v1}, 0);

        // Power-on fill: busy lasts DEPTH cycles, then every word reads zero
        busy_cnt0 = 0; busy_cnt1 = 0;
        rst_n = 1'b1;
        wait_idle(DEPTH0, DEPTH1);
        for (int i = 0; i < 16; i++) op(1'b0, 4'(i), '0, '0, 1'b1, 1'b1, 4'(15 - i), 1'b1);
        idle(3);

        // Byte merge and empty-enable write
        op(1'b1, 4'd3, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b0, 4'd3, '0, '0, 1'b1, 1'b1, 4'd3, 1'b1);
        idle(3);
        chk("merge_model", m0[3], 32'hAA22CC44);

        // Read-during-write collision at address 5
        op(1'b1, 4'd5, 32'h1, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b1, 4'd5, 32'h2, 4'hF, 1'b1, 1'b1, 4'd5, 1'b1);
        idle(3);

        // Back-to-back reads of 0,1,2 and same-address dual read
        for (int i = 0; i < 3; i++) op(1'b1, 4'(i), $urandom, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) op(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, 4'(i), 1'b1);
        op(1'b0, 4'd1, '0, '0, 1'b1, 1'b1, 4'd1, 1'b1);

        // Out-of-range address on dut1: write dropped, read returns zero
        op(1'b1, 4'd13, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b0, 4'd13, '0, '0, 1'b1, 1'b1, 4'd13, 1'b1);

        // Random mixed traffic
        for (int i = 0; i < 24; i++) begin
            op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b1);
        end
        idle(3);

        // Clear request: a read just before it completes, accesses during it are dropped
        op(1'b0, 4'd0, '0, '0, 1'b0, 1'b1, 4'd2, 1'b1);
        busy_cnt0 = 0; busy_cnt1 = 0;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        idle(5);
        op(1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1, 4'd1, 1'b0);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        wait_idle(DEPTH0, DEPTH1);
        model_zero();
        for (int i = 0; i < 16; i++) op(1'b0, 4'(15 - i), '0, '0, 1'b1, 1'b1, 4'(i), 1'b1);
        idle(3);

        // Reset in the middle of a fill restarts it from word 0
        for (int i = 0; i < 4; i++) op(1'b1, 4'(i), 32'h5A5A0000 | 32'(i + 1), 4'hF, 1'b0, 1'b0, 4'd0, 1'b1);
        op(1'b0, 4'd1, '0, '0, 1'b1, 1'b1, 4'd2, 1'b1);
        idle(3);
        rst_n = 1'b0;
        idle(1);
        busy_cnt0 = 0; busy_cnt1 = 0;
        rst_n = 1'b1;
        idle(7);
        rst_n = 1'b0;
        idle(2);
        chk("midfill_busy", {busy0, busy1}, 2'b11);
        chk("midfill_a_q0", a_q0, 0);
        chk("midfill_b_q1", b_q1, 0);
        busy_cnt0 = 0; busy_cnt1 = 0;
        rst_n = 1'b1;
        wait_idle(DEPTH0, DEPTH1);
        model_zero();
        for (int i = 0; i < 4; i++) op(1'b0, 4'(i), '0, '0, 1'b1, 1'b1, 4'(3 - i), 1'b1);
        idle(4);

        // Every expected read must have been answered
        chk("a0_pending", exp_a0_q.size(), 0);
        chk("b0_pending", exp_b0_q.size(), 0);
        chk("a1_pending", exp_a1_q.size(), 0);
        chk("b1_pending", exp_b1_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
